// File: rtl/nic_access_arbiter.sv
// nic_access_arbiter: round-robin, optionally locked sharing of one NIC CPU port among NUM_REQ requesters
module nic_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PACKET_WIDTH = 64,
  parameter int ADDR_WIDTH = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [PACKET_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]           addr,
  output logic [PACKET_WIDTH-1:0]         d_in,
  input  logic [PACKET_WIDTH-1:0]         d_out,
  output logic                            nicEn,
  output logic                            nicEnWR
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] ptr, owner, win, k, sel;
  logic [LW-1:0] lock_cnt;
  logic relock, start;
  always_comb begin
    win = '0;
    k = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = PW'((int'(ptr) + i) % NUM_REQ);
      win = req[k] ? k : win;
    end
    relock = state == RESP && req_lock[owner] && req[owner] && lock_cnt < LW'(LOCK_MAX - 1);
    start = (state == IDLE && |req) || relock;
    sel = state == IDLE ? win : owner;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      lock_cnt <= '0;
      gnt <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      addr <= '0;
      d_in <= '0;
      nicEn <= 1'b0;
      nicEnWR <= 1'b0;
    end else begin
      gnt <= '0;
      rsp_valid <= '0;
      addr <= '0;
      d_in <= '0;
      nicEn <= 1'b0;
      nicEnWR <= 1'b0;
      if (start) begin
        state <= ISSUE;
        owner <= sel;
        lock_cnt <= relock ? lock_cnt + LW'(1) : '0;
        gnt <= NUM_REQ'(1) << sel;
        nicEn <= 1'b1;
        nicEnWR <= req_wr[sel];
        addr <= req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        d_in <= req_data[sel*PACKET_WIDTH +: PACKET_WIDTH];
      end else if (state == ISSUE) begin
        state <= RESP;
        rsp_valid <= NUM_REQ'(1) << owner;
        ptr <= owner == PW'(NUM_REQ - 1) ? '0 : owner + PW'(1);
        if (!nicEnWR) rsp_data <= d_out;
      end else begin
        state <= IDLE;
        lock_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_nic_access_arbiter.sv
// tb_nic_access_arbiter: directed stimulus, scheduling model checked every cycle, plus literal pins
module tb_nic_access_arbiter;
  localparam int N = 4, PW = 64, AW = 2, LM = 4, DEPTH = 1024;
  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0, req_wr = '0, req_lock = '0;
  logic [AW-1:0] ra [N];
  logic [PW-1:0] rd [N];
  logic [N*AW-1:0] req_addr;
  logic [N*PW-1:0] req_data;
  logic [N-1:0] gnt, rsp_valid;
  logic [PW-1:0] rsp_data, d_in, d_out = '0;
  logic [AW-1:0] addr;
  logic nicEn, nicEnWR;
  int checks = 0, fails = 0, cyc = 0;
  assign req_addr = {ra[3], ra[2], ra[1], ra[0]};
  assign req_data = {rd[3], rd[2], rd[1], rd[0]};

  nic_access_arbiter #(.NUM_REQ(N), .PACKET_WIDTH(PW), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .addr(addr), .d_in(d_in), .d_out(d_out), .nicEn(nicEn), .nicEnWR(nicEnWR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // expected outputs per cycle, filled ahead of time by the model
  logic [N-1:0] e_gnt [DEPTH], e_rsp [DEPTH];
  logic e_en [DEPTH], e_wr [DEPTH], e_rdset [DEPTH];
  logic [AW-1:0] e_addr [DEPTH];
  logic [PW-1:0] e_din [DEPTH], e_rdv [DEPTH];
  logic [PW-1:0] cur_rd = '0;
  int mptr = 0, lk = 0, free_at = -1, lock_at = -1, lock_own = 0, mc = 0, w = 0;
  bit started = 0;

  task automatic clear_at(int c);
    e_gnt[c] = '0; e_rsp[c] = '0; e_en[c] = 0; e_wr[c] = 0; e_rdset[c] = 0;
    e_addr[c] = '0; e_din[c] = '0; e_rdv[c] = '0;
  endtask

  task automatic issue(int who, int n);
    e_gnt[n+1] = N'(1) << who;
    e_en[n+1] = 1;
    e_wr[n+1] = req_wr[who];
    e_addr[n+1] = ra[who];
    e_din[n+1] = rd[who];
    e_rsp[n+2] = N'(1) << who;
    mptr = (who + 1) % N;
    lock_at = n + 2;
    lock_own = who;
    free_at = -1;
  endtask

  always @(negedge clk) begin
    mc = cyc;
    if (started) begin
      if (e_rdset[mc]) cur_rd = e_rdv[mc];
      chk("gnt", gnt, e_gnt[mc]);
      chk("rsp_valid", rsp_valid, e_rsp[mc]);
      chk("nicEn", nicEn, e_en[mc]);
      chk("nicEnWR", nicEnWR, e_wr[mc]);
      chk("addr", addr, e_addr[mc]);
      chk("d_in", d_in, e_din[mc]);
      chk("rsp_data", rsp_data, cur_rd);
    end
    if (reset) begin
      for (int k = 1; k <= 3; k++) clear_at(mc + k);
      e_rdset[mc+1] = 1;
      e_rdv[mc+1] = '0;
      mptr = 0; lk = 0; free_at = mc + 1; lock_at = -1; started = 1;
    end else if (started) begin
      if (e_en[mc] && !e_wr[mc]) begin
        e_rdset[mc+1] = 1;
        e_rdv[mc+1] = d_out;
      end
      if (mc == lock_at) begin
        if (req[lock_own] && req_lock[lock_own] && lk < LM - 1) begin
          lk++;
          issue(lock_own, mc);
        end else begin
          lk = 0; lock_at = -1; free_at = mc + 1;
        end
      end else if (mc == free_at) begin
        if (req != '0) begin
          w = -1;
          for (int k = 0; k < N; k++) if (w < 0 && req[(mptr + k) % N]) w = (mptr + k) % N;
          lk = 0;
          issue(w, mc);
        end else free_at = mc + 1;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int idx_of(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  int t0, n, g0, g1;
  int gi [6], gc [6];
  int e3i [5] = '{0, 1, 2, 3, 0};
  int e3c [5] = '{1, 4, 7, 10, 13};
  int e4i [6] = '{0, 0, 0, 0, 1, 0};
  int e4c [6] = '{1, 3, 5, 7, 10, 13};

  initial begin
    for (int k = 0; k < DEPTH; k++) clear_at(k);
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rd[i] = '0;
    end
    step(3);
    chk("reset_gnt", gnt, 0);
    chk("reset_nicEn", nicEn, 0);
    chk("reset_rsp_data", rsp_data, 0);
    reset = 0;
    step(1);
    // single read by requester 2
    ra[2] = 2'd1; req = 4'b0100; d_out = 64'hA5;
    step(1);
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_en", nicEn, 1);
    chk("t1_wr", nicEnWR, 0);
    chk("t1_addr", addr, 1);
    req = '0;
    step(1);
    chk("t1_rsp", rsp_valid, 4'b0100);
    chk("t1_rdata", rsp_data, 64'hA5);
    step(2);
    // single write by requester 1
    req = 4'b0010; req_wr = 4'b0010; rd[1] = 64'hDEAD_BEEF;
    step(1);
    chk("t2_gnt", gnt, 4'b0010);
    chk("t2_en", nicEn, 1);
    chk("t2_wr", nicEnWR, 1);
    chk("t2_din", d_in, 64'hDEAD_BEEF);
    req = '0; req_wr = '0;
    step(1);
    chk("t2_en_drop", nicEn, 0);
    chk("t2_din_drop", d_in, 0);
    chk("t2_rsp", rsp_valid, 4'b0010);
    chk("t2_rdata_kept", rsp_data, 64'hA5);
    step(2);
    // all four held after reset
    reset = 1; step(2); reset = 0; step(1);
    req = 4'b1111; t0 = cyc; n = 0;
    for (int k = 0; k < 5; k++) begin gi[k] = -1; gc[k] = -1; end
    for (int k = 0; k < 14; k++) begin
      step(1);
      if (gnt != '0 && n < 5) begin
        gi[n] = idx_of(gnt); gc[n] = cyc - t0; n++;
      end
    end
    req = '0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_order", gi[k], e3i[k]);
      chk("t3_time", gc[k], e3c[k]);
    end
    step(3);
    // locked requester 0 against pending requester 1
    reset = 1; step(2); reset = 0; step(1);
    ra[0] = 2'd3; rd[0] = 64'h1234_5678_9ABC_DEF0; ra[1] = 2'd2; d_out = 64'h77;
    req_wr = 4'b0001; req = 4'b0011; req_lock = 4'b0001; t0 = cyc; n = 0; g0 = 0;
    for (int k = 0; k < 6; k++) begin gi[k] = -1; gc[k] = -1; end
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (gnt != '0) begin
        if (n < 6) begin gi[n] = idx_of(gnt); gc[n] = cyc - t0; end
        n++;
        if (gnt[0]) g0++;
        if (g0 == 6) begin req[0] = 0; req_lock[0] = 0; end
        if (gnt[1]) req[1] = 0;
      end
    end
    req_wr = '0;
    for (int k = 0; k < 6; k++) begin
      chk("t4_owner", gi[k], e4i[k]);
      chk("t4_time", gc[k], e4c[k]);
    end
    step(2);
    // reset while issuing, then ptr restarts at 0
    req = 4'b0100;
    step(1);
    chk("t5_gnt", gnt, 4'b0100);
    reset = 1; req = '0;
    step(1);
    chk("t5_en_off", nicEn, 0);
    chk("t5_gnt_off", gnt, 0);
    chk("t5_no_rsp", rsp_valid, 0);
    reset = 0; req = 4'b1001;
    step(1);
    chk("t5_first", gnt, 4'b0001);
    chk("t5_no_rsp2", rsp_valid, 0);
    req[0] = 0;
    step(1);
    chk("t5_rsp0", rsp_valid, 4'b0001);
    step(2);
    chk("t5_second", gnt, 4'b1000);
    req = '0;
    step(3);
    // requester 1 pulses while requester 0 holds a lock
    req = 4'b0001; req_lock = 4'b0001; g0 = 0; g1 = 0;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      if (k == 1) req[1] = 1;
      if (k == 2) req[1] = 0;
      if (gnt[0]) g0++;
      if (gnt[1]) g1++;
      if (g0 == 3) begin req[0] = 0; req_lock[0] = 0; end
    end
    chk("t6_req1_never", g1, 0);
    chk("t6_req0_count", g0, 3);
    step(2);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
